// File: rtl/cpu_core.sv
// cpu_core: multi-cycle 8-bit CPU (FETCH/DECODE/EXECUTE) running 32-bit instructions
// from a flattened read-only program bus; all architectural state is exported for debug.
`default_nettype none

module cpu_core #(
  parameter int RAM_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [RAM_SIZE*32-1:0]  ram,
  output logic [7:0]              flags,
  output logic [7:0]              al,
  output logic [7:0]              bl,
  output logic [7:0]              cl,
  output logic [7:0]              dl,
  output logic [31:0]             ir,
  output logic [15:0]             clks,
  output logic [7:0]              pc,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t      cur_state, nxt_state;
  logic [7:0]  regs [4];
  logic [3:0]  flag_q;            // {V, S, C, Z}
  logic [31:0] fetch_word;

  logic [7:0]  op, imm, op_a, op_b, alu_res;
  logic [1:0]  rd, rs;
  logic [8:0]  wide;
  logic        new_c, new_v, wr_reg, wr_flags, take_jmp;

  assign op  = ir[31:24];
  assign rd  = ir[17:16];
  assign rs  = ir[9:8];
  assign imm = ir[7:0];

  // Words at or beyond RAM_SIZE read as NOP.
  always_comb begin
    fetch_word = 32'h0;
    for (int i = 0; i < RAM_SIZE; i++) begin
      if ({24'd0, pc} == i[31:0])
        fetch_word = ram[i*32 +: 32];
    end
  end

  always_comb begin
    op_a     = regs[rd];
    op_b     = regs[rs];
    wide     = 9'd0;
    alu_res  = 8'd0;
    new_c    = flag_q[1];
    new_v    = 1'b0;
    wr_reg   = 1'b0;
    wr_flags = 1'b0;
    take_jmp = 1'b0;
    case (op)
      8'h01: begin alu_res = imm;  wr_reg = 1'b1; end
      8'h02: begin alu_res = op_b; wr_reg = 1'b1; end
      8'h03, 8'h09, 8'h0B: begin
        if (op == 8'h09)      op_b = imm;
        else if (op == 8'h0B) op_b = 8'd1;
        wide     = {1'b0, op_a} + {1'b0, op_b};
        alu_res  = wide[7:0];
        if (op != 8'h0B) new_c = wide[8];
        new_v    = (op_a[7] == op_b[7]) && (alu_res[7] != op_a[7]);
        wr_reg   = 1'b1;
        wr_flags = 1'b1;
      end
      8'h04, 8'h08, 8'h0A, 8'h0C: begin
        if (op == 8'h0A)      op_b = imm;
        else if (op == 8'h0C) op_b = 8'd1;
        // Bit 8 of the widened difference is the unsigned borrow.
        wide     = {1'b0, op_a} - {1'b0, op_b};
        alu_res  = wide[7:0];
        if (op != 8'h0C) new_c = wide[8];
        new_v    = (op_a[7] != op_b[7]) && (alu_res[7] != op_a[7]);
        wr_reg   = (op != 8'h08);
        wr_flags = 1'b1;
      end
      8'h05, 8'h06, 8'h07: begin
        if (op == 8'h05)      alu_res = op_a & op_b;
        else if (op == 8'h06) alu_res = op_a | op_b;
        else                  alu_res = op_a ^ op_b;
        new_c    = 1'b0;
        wr_reg   = 1'b1;
        wr_flags = 1'b1;
      end
      8'h10: take_jmp = 1'b1;
      8'h11: take_jmp = flag_q[0];
      8'h12: take_jmp = ~flag_q[0];
      8'h13: take_jmp = flag_q[1];
      8'h14: take_jmp = ~flag_q[1];
      default: ;
    endcase
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: nxt_state = S_EXEC;
      S_EXEC:   nxt_state = (op == 8'hFF) ? S_HALT : S_FETCH;
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= S_FETCH;
    else        cur_state <= nxt_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= 8'd0;
      ir     <= 32'd0;
      clks   <= 16'd0;
      flag_q <= 4'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
    end else begin
      if (cur_state != S_HALT) clks <= clks + 16'd1;
      case (cur_state)
        S_FETCH:  ir <= fetch_word;
        S_DECODE: pc <= pc + 8'd1;
        S_EXEC: begin
          if (wr_reg)   regs[rd] <= alu_res;
          if (wr_flags) flag_q   <= {new_v, alu_res[7], new_c, (alu_res == 8'd0)};
          if (take_jmp) pc       <= imm;
        end
        default: ;
      endcase
    end
  end

  assign flags = {4'b0000, flag_q};
  assign al    = regs[0];
  assign bl    = regs[1];
  assign cl    = regs[2];
  assign dl    = regs[3];
  assign state = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed, table-driven checks of cpu_core plus hand-written
// sequences for reset, halt and fetch-only sampling of the program bus.
`default_nettype none

module tb_cpu_core;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] ram = '0;
  logic [7:0]   flags, al, bl, cl, dl, pc;
  logic [31:0]  ir;
  logic [15:0]  clks;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  cpu_core #(.RAM_SIZE(8)) dut (
    .clk(clk), .reset(reset), .ram(ram), .flags(flags),
    .al(al), .bl(bl), .cl(cl), .dl(dl),
    .ir(ir), .clks(clks), .pc(pc), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [255:0] prog;
    int           edges;
    logic [7:0]   al, bl, cl, dl, pc, flags;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [255:0] prog5(input logic [31:0] w0, w1, w2, w3, w4);
    return {96'h0, w4, w3, w2, w1, w0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic restart(input logic [255:0] prog);
    reset = 1'b0;
    ram   = prog;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"mov12",   prog5(32'h01000011, 32'h01010022, 32'h01020033, 32'h01030044, 32'h10000000), 12, 8'h11, 8'h22, 8'h33, 8'h44, 8'd4, 8'h00};
    vecs[1]  = '{"mov15",   prog5(32'h01000011, 32'h01010022, 32'h01020033, 32'h01030044, 32'h10000000), 15, 8'h11, 8'h22, 8'h33, 8'h44, 8'd0, 8'h00};
    vecs[2]  = '{"mov30",   prog5(32'h01000011, 32'h01010022, 32'h01020033, 32'h01030044, 32'h10000000), 30, 8'h11, 8'h22, 8'h33, 8'h44, 8'd0, 8'h00};
    vecs[3]  = '{"addimm",  prog5(32'h010000FF, 32'h09000001, 32'h0, 32'h0, 32'h0), 6, 8'h00, 8'h00, 8'h00, 8'h00, 8'd2, 8'h03};
    vecs[4]  = '{"inc",     prog5(32'h0101007F, 32'h0B010000, 32'h0, 32'h0, 32'h0), 6, 8'h00, 8'h80, 8'h00, 8'h00, 8'd2, 8'h0C};
    vecs[5]  = '{"and",     prog5(32'h010000FF, 32'h09000001, 32'h05000000, 32'h0, 32'h0), 9, 8'h00, 8'h00, 8'h00, 8'h00, 8'd3, 8'h01};
    vecs[6]  = '{"jz_take", prog5(32'h01000005, 32'h01010005, 32'h08000100, 32'h11000006, 32'h0), 12, 8'h05, 8'h05, 8'h00, 8'h00, 8'd6, 8'h01};
    vecs[7]  = '{"jz_not",  prog5(32'h01000006, 32'h01010005, 32'h08000100, 32'h11000006, 32'h0), 12, 8'h06, 8'h05, 8'h00, 8'h00, 8'd4, 8'h00};
    vecs[8]  = '{"sub",     prog5(32'h01000003, 32'h01010005, 32'h04000100, 32'h0, 32'h0), 9, 8'hFE, 8'h05, 8'h00, 8'h00, 8'd3, 8'h06};
    vecs[9]  = '{"subimm",  prog5(32'h01000080, 32'h0A000001, 32'h0, 32'h0, 32'h0), 6, 8'h7F, 8'h00, 8'h00, 8'h00, 8'd2, 8'h08};
    vecs[10] = '{"xor",     prog5(32'h0102000F, 32'h010300F0, 32'h07020300, 32'h0, 32'h0), 9, 8'h00, 8'h00, 8'hFF, 8'hF0, 8'd3, 8'h04};
    vecs[11] = '{"dec",     prog5(32'h010000FF, 32'h09000001, 32'h0C000000, 32'h0, 32'h0), 9, 8'hFF, 8'h00, 8'h00, 8'h00, 8'd3, 8'h06};
    vecs[12] = '{"jc_movrr",prog5(32'h010000FF, 32'h09000001, 32'h13000005, 32'h01030099, 32'h0) | (256'h02020000 << 160), 12, 8'h00, 8'h00, 8'h00, 8'h00, 8'd6, 8'h03};
    vecs[13] = '{"nop_wrap",prog5(32'h09000001, 32'h0, 32'h0, 32'h0, 32'h0), 768, 8'h01, 8'h00, 8'h00, 8'h00, 8'd0, 8'h00};

    // Reset state and the first few FETCH/DECODE/EXECUTE steps.
    reset = 1'b0;
    ram   = prog5(32'h01000011, 32'h01010022, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {30'd0, state}, 0);
    check("rst_pc", {24'd0, pc}, 0);
    check("rst_ir", ir, 0);
    check("rst_clks", {16'd0, clks}, 0);
    check("rst_regs", {al, bl, cl, dl}, 0);
    check("rst_flags", {24'd0, flags}, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("seq_state", {30'd0, state}, k % 3);
      check("seq_clks", {16'd0, clks}, k);
      if (k == 1) check("seq_ir", ir, 32'h01000011);
      if (k == 2) check("seq_pc", {24'd0, pc}, 1);
    end
    check("seq_al", {24'd0, al}, 8'h11);

    // Asynchronous reset in the middle of the MOV BL instruction.
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_state", {30'd0, state}, 0);
    check("async_pc", {24'd0, pc}, 0);
    check("async_clks", {16'd0, clks}, 0);
    check("async_regs", {al, bl}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_bl", {24'd0, bl}, 0);

    // Program bus changes outside FETCH must not affect the running instruction.
    restart(prog5(32'h01000011, 32'h0, 32'h0, 32'h0, 32'h0));
    @(posedge clk); #1;
    ram = prog5(32'h01000022, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("ram_sample_al", {24'd0, al}, 8'h11);

    // Halt at word 2: clks freezes at 9 and state stays stable.
    restart(prog5(32'h01000011, 32'h01010022, 32'hFF000000, 32'h01020033, 32'h0));
    repeat (9) @(posedge clk);
    #1;
    check("halt_state", {30'd0, state}, 3);
    check("halt_clks", {16'd0, clks}, 9);
    repeat (20) @(posedge clk);
    #1;
    check("halt_state20", {30'd0, state}, 3);
    check("halt_clks20", {16'd0, clks}, 9);
    check("halt_pc20", {24'd0, pc}, 3);
    check("halt_regs20", {al, bl, cl, dl}, 32'h11220000);

    for (int i = 0; i < 14; i++) begin
      restart(vecs[i].prog);
      repeat (vecs[i].edges) @(posedge clk);
      #1;
      check({vecs[i].name, "_al"}, {24'd0, al}, {24'd0, vecs[i].al});
      check({vecs[i].name, "_bl"}, {24'd0, bl}, {24'd0, vecs[i].bl});
      check({vecs[i].name, "_cl"}, {24'd0, cl}, {24'd0, vecs[i].cl});
      check({vecs[i].name, "_dl"}, {24'd0, dl}, {24'd0, vecs[i].dl});
      check({vecs[i].name, "_pc"}, {24'd0, pc}, {24'd0, vecs[i].pc});
      check({vecs[i].name, "_flags"}, {24'd0, flags}, {24'd0, vecs[i].flags});
      check({vecs[i].name, "_state"}, {30'd0, state}, 0);
      check({vecs[i].name, "_clks"}, {16'd0, clks}, vecs[i].edges);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
